// File: rtl/collective_pkg.sv
// Shared definitions for the collective router injection path: opcodes, flit
// layout, lane indices and the scheduler state encoding.
package collective_pkg;

    localparam int FLIT_W    = 84;
    localparam int NUM_LANES = 5;
    localparam int NUM_DIRS  = 4;

    localparam int W_TYPE = 3;
    localparam int W_NODE = 9;
    localparam int W_CTX  = 8;
    localparam int W_SEQ  = 8;
    localparam int W_OP   = 4;
    localparam int W_DATA = 32;

    // Lane order matches the inj_stall bit order.
    localparam int LANE_XPOS = 0;
    localparam int LANE_YPOS = 1;
    localparam int LANE_XNEG = 2;
    localparam int LANE_YNEG = 3;
    localparam int LANE_RME  = 4;

    localparam logic [W_OP-1:0] OP_SCAN            = 4'b0011;
    localparam logic [W_OP-1:0] OP_EXSCAN          = 4'b0100;
    localparam logic [W_OP-1:0] OP_BARRIER         = 4'b0101;
    localparam logic [W_OP-1:0] OP_BCAST           = 4'b0110;
    localparam logic [W_OP-1:0] OP_GATHER          = 4'b0111;
    localparam logic [W_OP-1:0] OP_SCATTER         = 4'b1000;
    localparam logic [W_OP-1:0] OP_ALLTOALL        = 4'b1001;
    localparam logic [W_OP-1:0] OP_ALLGATHER       = 4'b1010;
    localparam logic [W_OP-1:0] OP_REDUCE_SCATTER  = 4'b1011;
    localparam logic [W_OP-1:0] OP_REDUCE          = 4'b1100;
    localparam logic [W_OP-1:0] OP_REDUCE_LOCAL    = 4'b1101;
    localparam logic [W_OP-1:0] OP_ALLREDUCE       = 4'b1110;
    localparam logic [W_OP-1:0] OP_LARGE_ALLREDUCE = 4'b1111;

    localparam logic [W_TYPE-1:0] FT_DIR = 3'b001;
    localparam logic [W_TYPE-1:0] FT_RED = 3'b011;
    localparam logic [W_TYPE-1:0] FT_RME = 3'b101;

    // Field order is MSB first: type at [83:81] down to data at [31:0].
    typedef struct packed {
        logic [W_TYPE-1:0] ftype;
        logic [W_NODE-1:0] dst;
        logic [W_NODE-1:0] src;
        logic [W_NODE-1:0] rank;
        logic [W_CTX-1:0]  ctx;
        logic [W_SEQ-1:0]  seq;
        logic [1:0]        rsvd;
        logic [W_OP-1:0]   op;
        logic [W_DATA-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DONE,
        S_GAP
    } sched_state_e;

    function automatic logic is_reduce_class(input logic [W_OP-1:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/collective_flit_pack.sv
// Combinational flit builder; one instance per injection lane.
module collective_flit_pack
    import collective_pkg::*;
(
    input  logic [W_TYPE-1:0] ftype_i,
    input  logic [W_NODE-1:0] dst_i,
    input  logic [W_NODE-1:0] src_i,
    input  logic [W_NODE-1:0] rank_i,
    input  logic [W_CTX-1:0]  ctx_i,
    input  logic [W_SEQ-1:0]  seq_i,
    input  logic [W_OP-1:0]   op_i,
    input  logic [W_DATA-1:0] data_i,
    output logic [FLIT_W-1:0] flit_o
);

    flit_t flit;

    always_comb begin
        flit.ftype = ftype_i;
        flit.dst   = dst_i;
        flit.src   = src_i;
        flit.rank  = rank_i;
        flit.ctx   = ctx_i;
        flit.seq   = seq_i;
        flit.rsvd  = 2'b00;
        flit.op    = op_i;
        flit.data  = data_i;
    end

    assign flit_o = flit;

endmodule

// File: rtl/collective_inject_sched.sv
// Per-node collective injection scheduler: takes one host command, pulses flits
// onto the four directional ports and reduce_me, retrying stalled lanes until done or timeout.
module collective_inject_sched
    import collective_pkg::*;
#(
    parameter logic [8:0] NODE_ID     = 9'd0,
    parameter logic [8:0] LOCAL_RANK  = 9'd0,
    parameter logic [7:0] CONTEXT_ID  = 8'd0,
    parameter int         STALL_LIMIT = 16,
    parameter int         INJ_GAP     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [7:0]        cmd_seq,
    input  logic [31:0]       cmd_data,
    input  logic [3:0]        cmd_dir_en,
    input  logic [8:0]        cmd_dst_xpos,
    input  logic [8:0]        cmd_dst_ypos,
    input  logic [8:0]        cmd_dst_xneg,
    input  logic [8:0]        cmd_dst_yneg,
    input  logic [4:0]        inj_stall,
    output logic [83:0]       in_xpos_inject,
    output logic [83:0]       in_ypos_inject,
    output logic [83:0]       in_xneg_inject,
    output logic [83:0]       in_yneg_inject,
    output logic [83:0]       reduce_me,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam int GW = (INJ_GAP < 2) ? 1 : $clog2(INJ_GAP);

    sched_state_e                          state_q, state_d;
    logic [NUM_LANES-1:0]                  rem_q, rem_d;
    logic [TW-1:0]                         tmo_q, tmo_d;
    logic [GW-1:0]                         gap_q, gap_d;
    logic                                  errf_q, errf_d;
    logic [NUM_LANES-1:0][FLIT_W-1:0]      out_q, out_d;
    logic                                  done_q, done_d;
    logic                                  err_q, err_d;

    logic [W_OP-1:0]                       op_q;
    logic [W_SEQ-1:0]                      seq_q;
    logic [W_DATA-1:0]                     data_q;
    logic [NUM_DIRS-1:0][W_NODE-1:0]       dst_q;

    logic [NUM_LANES-1:0][W_TYPE-1:0]      lane_type;
    logic [NUM_LANES-1:0][W_NODE-1:0]      lane_dst;
    logic [NUM_LANES-1:0][FLIT_W-1:0]      lane_flit;
    logic                                  accept;

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != S_IDLE);

    // y-axis flits carry the reduce type so downstream routers combine them.
    always_comb begin
        for (int i = 0; i < NUM_DIRS; i++) begin
            lane_dst[i]  = dst_q[i];
            lane_type[i] = (i[0] && is_reduce_class(op_q)) ? FT_RED : FT_DIR;
        end
        lane_dst[LANE_RME]  = NODE_ID;
        lane_type[LANE_RME] = FT_RME;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        collective_flit_pack u_pack (
            .ftype_i (lane_type[g]),
            .dst_i   (lane_dst[g]),
            .src_i   (NODE_ID),
            .rank_i  (LOCAL_RANK),
            .ctx_i   (CONTEXT_ID),
            .seq_i   (seq_q),
            .op_i    (op_q),
            .data_i  (data_q),
            .flit_o  (lane_flit[g])
        );
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        errf_d  = errf_q;
        out_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tmo_d  = '0;
                    errf_d = 1'b0;
                    rem_d  = {is_reduce_class(cmd_op), cmd_dir_en};
                    if (cmd_op < OP_SCAN) begin
                        rem_d   = '0;
                        errf_d  = 1'b1;
                        state_d = S_DONE;
                    end else if ({is_reduce_class(cmd_op), cmd_dir_en} == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (rem_q[i] && !inj_stall[i]) out_d[i] = lane_flit[i];
                end
                rem_d = rem_q & inj_stall;
                // Completion wins over timeout when the last lane fires on the limit cycle.
                if (rem_d == '0) begin
                    state_d = S_DONE;
                end else if (tmo_q == TW'(STALL_LIMIT - 1)) begin
                    rem_d   = '0;
                    errf_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                err_d   = errf_q;
                gap_d   = '0;
                state_d = (INJ_GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_q == GW'(INJ_GAP - 1)) state_d = S_IDLE;
                else                            gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            errf_q  <= 1'b0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            seq_q   <= '0;
            data_q  <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            errf_q  <= errf_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                op_q   <= cmd_op;
                seq_q  <= cmd_seq;
                data_q <= cmd_data;
                dst_q  <= {cmd_dst_yneg, cmd_dst_xneg, cmd_dst_ypos, cmd_dst_xpos};
            end
        end
    end

    assign in_xpos_inject = out_q[LANE_XPOS];
    assign in_ypos_inject = out_q[LANE_YPOS];
    assign in_xneg_inject = out_q[LANE_XNEG];
    assign in_yneg_inject = out_q[LANE_YNEG];
    assign reduce_me      = out_q[LANE_RME];
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_collective_inject_sched.sv
// Bench for collective_inject_sched: directed vector table, reset/back-to-back
// sequences and randomized commands checked against a lane-fire-time model.
module tb_collective_inject_sched;

    localparam logic [8:0] NODE = 9'h015;
    localparam logic [8:0] RANK = 9'h0C3;
    localparam logic [7:0] CTX  = 8'hA5;
    localparam int         L    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_op, cmd_dir_en;
    logic [7:0]  cmd_seq;
    logic [31:0] cmd_data;
    logic [8:0]  cmd_dst_xpos, cmd_dst_ypos, cmd_dst_xneg, cmd_dst_yneg;
    logic [4:0]  inj_stall;
    logic [83:0] in_xpos_inject, in_ypos_inject, in_xneg_inject, in_yneg_inject, reduce_me;
    logic        busy, done, err;

    collective_inject_sched #(
        .NODE_ID(NODE), .LOCAL_RANK(RANK), .CONTEXT_ID(CTX),
        .STALL_LIMIT(L), .INJ_GAP(1)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_seq(cmd_seq), .cmd_data(cmd_data), .cmd_dir_en(cmd_dir_en),
        .cmd_dst_xpos(cmd_dst_xpos), .cmd_dst_ypos(cmd_dst_ypos),
        .cmd_dst_xneg(cmd_dst_xneg), .cmd_dst_yneg(cmd_dst_yneg),
        .inj_stall(inj_stall),
        .in_xpos_inject(in_xpos_inject), .in_ypos_inject(in_ypos_inject),
        .in_xneg_inject(in_xneg_inject), .in_yneg_inject(in_yneg_inject),
        .reduce_me(reduce_me), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      op;
        logic [3:0]      dir;
        logic [3:0][8:0] dst;    // {yneg,xneg,ypos,xpos}
        logic [7:0]      seq;
        logic [31:0]     data;
        logic [3:0][4:0] stall;  // stall vector for ISSUE cycle k=0..3
        int              dofs;   // done visible at cycle T+dofs
        logic            derr;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int m_fk[5];
    int m_dofs;
    logic m_err;
    vec_t tbl[12];

    function automatic vec_t mkv(logic [3:0] op, logic [3:0] dir, logic [3:0][8:0] dst,
                                 logic [7:0] seq, logic [31:0] data, logic [3:0][4:0] stall,
                                 int dofs, logic derr);
        vec_t v;
        v.op = op; v.dir = dir; v.dst = dst; v.seq = seq; v.data = data;
        v.stall = stall; v.dofs = dofs; v.derr = derr;
        return v;
    endfunction

    function automatic logic [83:0] mk_flit(logic [2:0] t, logic [8:0] d, logic [7:0] seq,
                                            logic [3:0] op, logic [31:0] data);
        return {t, d, NODE, RANK, CTX, seq, 2'b00, op, data};
    endfunction

    function automatic logic [4:0] stall_at(vec_t c, int k);
        return (k < L) ? c.stall[k] : 5'd0;
    endfunction

    // Each enabled lane fires at the first ISSUE cycle whose stall bit is clear;
    // a lane still blocked after L cycles aborts the command.
    task automatic model(input vec_t c);
        logic [4:0] mask;
        int last, k;
        for (int i = 0; i < 5; i++) m_fk[i] = -1;
        m_err = 1'b0;
        m_dofs = 1;
        mask = {c.op >= 4'd12, c.dir};
        if (c.op < 4'd3) begin
            m_err = 1'b1;
        end else if (mask != 5'd0) begin
            last = 0;
            for (int i = 0; i < 5; i++) begin
                if (mask[i]) begin
                    k = 0;
                    while (k < L && stall_at(c, k)[i]) k++;
                    if (k == L) m_err = 1'b1;
                    else begin
                        m_fk[i] = k;
                        if (k > last) last = k;
                    end
                end
            end
            m_dofs = m_err ? L + 1 : last + 2;
        end
    endtask

    function automatic logic [419:0] exp_flits(vec_t c, int k);
        logic [4:0][83:0] e;
        logic [2:0] ty;
        e = '0;
        ty = (c.op >= 4'd12) ? 3'b011 : 3'b001;
        if (k >= 1) begin
            if (m_fk[0] == k - 1) e[0] = mk_flit(3'b001, c.dst[0], c.seq, c.op, c.data);
            if (m_fk[1] == k - 1) e[1] = mk_flit(ty,     c.dst[1], c.seq, c.op, c.data);
            if (m_fk[2] == k - 1) e[2] = mk_flit(3'b001, c.dst[2], c.seq, c.op, c.data);
            if (m_fk[3] == k - 1) e[3] = mk_flit(ty,     c.dst[3], c.seq, c.op, c.data);
            if (m_fk[4] == k - 1) e[4] = mk_flit(3'b101, NODE,     c.seq, c.op, c.data);
        end
        return e;
    endfunction

    function automatic logic [419:0] act_flits();
        return {reduce_me, in_yneg_inject, in_xneg_inject, in_ypos_inject, in_xpos_inject};
    endfunction

    task automatic chk(input string nm, input int k, input logic [419:0] act, input logic [419:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    task automatic drive_cmd(input vec_t c);
        cmd_valid = 1'b1;
        cmd_op = c.op; cmd_dir_en = c.dir; cmd_seq = c.seq; cmd_data = c.data;
        cmd_dst_xpos = c.dst[0]; cmd_dst_ypos = c.dst[1];
        cmd_dst_xneg = c.dst[2]; cmd_dst_yneg = c.dst[3];
    endtask

    task automatic drive_junk();
        cmd_valid = 1'b1;
        cmd_op = 4'($urandom); cmd_dir_en = 4'($urandom); cmd_seq = 8'($urandom);
        cmd_data = $urandom;
        cmd_dst_xpos = 9'($urandom); cmd_dst_ypos = 9'($urandom);
        cmd_dst_xneg = 9'($urandom); cmd_dst_yneg = 9'($urandom);
    endtask

    // Entered at a negedge where the DUT should be idle; leaves at the negedge
    // one cycle after done, i.e. the first cycle a new command may be accepted.
    task automatic run_cmd(input vec_t c, input int dofs, input logic derr, input bit hold);
        model(c);
        chk("ready_at_start", 0, 420'(cmd_ready), 420'(1));
        drive_cmd(c);
        inj_stall = 5'($urandom);
        for (int k = 0; k <= dofs; k++) begin
            @(negedge clk);
            if (hold) drive_junk();
            else      cmd_valid = 1'b0;
            inj_stall = (k < L) ? c.stall[k] : 5'($urandom);
            chk("flits", k, act_flits(), exp_flits(c, k));
            chk("done",  k, 420'(done), 420'(k == dofs));
            chk("err",   k, 420'(err),  420'((k == dofs) && derr));
            chk("busy",  k, 420'(busy), 420'(1));
            chk("cmd_ready_busy", k, 420'(cmd_ready), 420'(0));
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dir_en = '0; cmd_seq = '0; cmd_data = '0;
        cmd_dst_xpos = '0; cmd_dst_ypos = '0; cmd_dst_xneg = '0; cmd_dst_yneg = '0; inj_stall = '0;

        tbl[0]  = mkv(4'hA, 4'b0011, {9'd0, 9'd0, 9'd8, 9'd1}, 8'h01, 32'd1, '0, 2, 1'b0);
        tbl[1]  = mkv(4'hE, 4'b1001, {9'h44, 9'h33, 9'h22, 9'h11}, 8'h02, 32'hDEADBEEF,
                      {5'h00, 5'h08, 5'h08, 5'h08}, 5, 1'b0);
        tbl[2]  = mkv(4'hA, 4'b0001, {9'h1, 9'h2, 9'h3, 9'h4}, 8'h03, 32'h12345678,
                      {5'h01, 5'h01, 5'h01, 5'h01}, 5, 1'b1);
        tbl[3]  = mkv(4'h1, 4'b1111, {9'h5, 9'h6, 9'h7, 9'h8}, 8'h04, 32'hCAFE0001, '0, 1, 1'b1);
        tbl[4]  = mkv(4'h7, 4'b0000, {9'h5, 9'h6, 9'h7, 9'h8}, 8'h05, 32'hCAFE0002, '0, 1, 1'b0);
        tbl[5]  = mkv(4'hF, 4'b1111, {9'h1FF, 9'h100, 9'h0AA, 9'h155}, 8'h06, 32'hFFFFFFFF, '0, 2, 1'b0);
        tbl[6]  = mkv(4'h3, 4'b0100, {9'h9, 9'h1A, 9'hB, 9'hC}, 8'h07, 32'h00000003, '0, 2, 1'b0);
        tbl[7]  = mkv(4'h2, 4'b1111, {9'h9, 9'h1A, 9'hB, 9'hC}, 8'h08, 32'h00000004, '0, 1, 1'b1);
        tbl[8]  = mkv(4'hC, 4'b0000, {9'h9, 9'h1A, 9'hB, 9'hC}, 8'h09, 32'h0BADF00D, '0, 2, 1'b0);
        tbl[9]  = mkv(4'hB, 4'b1010, {9'h21, 9'h22, 9'h23, 9'h24}, 8'h0A, 32'h55AA55AA,
                      {5'h00, 5'h00, 5'h08, 5'h0A}, 4, 1'b0);
        tbl[10] = mkv(4'hD, 4'b0000, {9'h0, 9'h0, 9'h0, 9'h0}, 8'h0B, 32'h13579BDF,
                      {5'h00, 5'h10, 5'h10, 5'h10}, 5, 1'b0);
        tbl[11] = mkv(4'hE, 4'b0001, {9'h31, 9'h32, 9'h33, 9'h34}, 8'h0C, 32'h2468ACE0,
                      {5'h10, 5'h10, 5'h10, 5'h10}, 5, 1'b1);

        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 0, 420'(cmd_ready), 420'(0));
        end
        chk("rst_flits", 0, act_flits(), '0);
        chk("rst_flags", 0, 420'({busy, done, err}), 420'(0));
        rst = 1'b0;
        #1;

        // Directed table, applied back to back with junk commands held valid while busy.
        for (int i = 0; i < 12; i++) run_cmd(tbl[i], tbl[i].dofs, tbl[i].derr, 1'b1);

        // Reset in the middle of ISSUE with every lane stalled.
        v = mkv(4'hE, 4'b1111, {9'h7, 9'h6, 9'h5, 9'h4}, 8'h77, 32'h0F0F0F0F,
                {5'h1F, 5'h1F, 5'h1F, 5'h1F}, 0, 1'b0);
        chk("mid_rst_ready0", 0, 420'(cmd_ready), 420'(1));
        drive_cmd(v);
        @(negedge clk);
        cmd_valid = 1'b0; inj_stall = 5'h1F;
        chk("mid_rst_busy", 0, 420'(busy), 420'(1));
        @(negedge clk);
        chk("mid_rst_flits_pre", 1, act_flits(), '0);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready_in_rst", 1, 420'(cmd_ready), 420'(0));
        @(negedge clk);
        chk("mid_rst_flits", 2, act_flits(), '0);
        chk("mid_rst_flags", 2, 420'({busy, done, err}), 420'(0));
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_after", 2, 420'(cmd_ready), 420'(1));
        for (int k = 3; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", k, 420'({busy, done, err}), 420'(0));
            chk("post_rst_flits", k, act_flits(), '0);
        end

        // Randomized commands against the fire-time model.
        for (int n = 0; n < 60; n++) begin
            v.op    = 4'($urandom_range(0, 15));
            v.dir   = 4'($urandom);
            v.dst   = {9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom)};
            v.seq   = 8'($urandom);
            v.data  = $urandom;
            for (int k = 0; k < L; k++) v.stall[k] = 5'($urandom) & 5'($urandom);
            model(v);
            run_cmd(v, m_dofs, m_err, n[0]);
        end

        cmd_valid = 1'b0;
        inj_stall = '0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
